// File: rtl/int_seq_pkg.sv
// Shared types and constants for the 6502 interrupt/reset sequencer.
// Holds the sequence states, the source encoding, the fixed vectors and the vector selection.
package int_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_T5   = 3'd5,
      ST_T6   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      SRC_RST = 2'd0,
      SRC_NMI = 2'd1,
      SRC_IRQ = 2'd2,
      SRC_BRK = 2'd3
   } src_t;

   localparam logic [15:0] VEC_NMI    = 16'hFFFA;
   localparam logic [15:0] VEC_RST    = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
   localparam logic [7:0]  STACK_PAGE = 8'h01;

   // A pending or freshly arrived NMI takes over the vector of an IRQ or BRK sequence.
   // Reset never gives up its vector.
   function automatic logic [15:0] vec_select(input src_t src, input logic nmi_seen);
      logic [15:0] vec;
      vec = VEC_IRQ;
      case (src)
         SRC_RST: vec = VEC_RST;
         SRC_NMI: vec = VEC_NMI;
         default: vec = nmi_seen ? VEC_NMI : VEC_IRQ;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/nmi_edge.sv
// NMI rising-edge detector with a sticky pending flag and a clear input.
// A new edge wins over a same-cycle clear; edges while pending are absorbed.
module nmi_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_nmi,
   input  logic i_clr,
   output logic o_rise,
   output logic o_pend
);

   logic prev_q;
   logic pend_q, pend_d;

   assign o_rise = i_nmi & ~prev_q;
   assign o_pend = pend_q;

   always_comb begin
      pend_d = pend_q;
      if (o_rise) begin
         pend_d = 1'b1;
      end else if (i_clr) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         prev_q <= i_nmi;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer: arbitrates RST/NMI/IRQ/BRK and steps the 7-cycle stack/vector sequence.
// Accept-to-done is 6 cycles (5 for BRK); o_busy holds the decoder off for the whole sequence.
module int_sequencer
   import int_seq_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_nmi,
   input  logic        i_irq,
   input  logic        i_iflag,
   input  logic        i_fetch,
   input  logic        i_brk,
   input  logic [7:0]  i_s,
   output logic        o_busy,
   output logic        o_force_brk,
   output logic        o_addr_en,
   output logic [15:0] o_addr,
   output logic        o_rw,
   output logic        o_push_pch,
   output logic        o_push_pcl,
   output logic        o_push_p,
   output logic        o_b_flag,
   output logic        o_dec_s,
   output logic        o_vec_lo,
   output logic        o_vec_hi,
   output logic        o_set_i,
   output logic        o_done
);

   state_t      state_q, state_d;
   src_t        src_q, src_d;
   logic [15:0] vec_q, vec_d;
   logic        rst_pend_q, rst_pend_d;

   logic        nmi_rise;
   logic        nmi_pend;
   logic        nmi_clr;
   logic        irq_ok;
   logic        accept;
   logic        is_rst;

   nmi_edge u_nmi_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_nmi  (i_nmi),
      .i_clr  (nmi_clr),
      .o_rise (nmi_rise),
      .o_pend (nmi_pend)
   );

   assign irq_ok = i_irq & ~i_iflag;
   assign accept = (state_q == ST_IDLE) & i_fetch & ~i_rst & (rst_pend_q | nmi_pend | irq_ok);
   assign is_rst = (src_q == SRC_RST);

   // Next-state, source/vector capture and pending-flag clears.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      vec_d       = vec_q;
      rst_pend_d  = rst_pend_q;
      nmi_clr     = 1'b0;
      o_force_brk = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               o_force_brk = 1'b1;
               state_d     = ST_T1;
               if (rst_pend_q) begin
                  src_d = SRC_RST;
               end else if (nmi_pend) begin
                  src_d = SRC_NMI;
               end else begin
                  src_d = SRC_IRQ;
               end
            end else if (i_brk) begin
               src_d   = SRC_BRK;
               state_d = ST_T2;
            end
         end
         ST_T1: state_d = ST_T2;
         ST_T2: state_d = ST_T3;
         ST_T3: state_d = ST_T4;
         ST_T4: begin
            state_d = ST_T5;
            vec_d   = vec_select(src_q, nmi_pend | nmi_rise);
         end
         ST_T5: begin
            state_d = ST_T6;
            nmi_clr = (vec_q == VEC_NMI);
            if (is_rst) begin
               rst_pend_d = 1'b0;
            end
         end
         ST_T6:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus and datapath strobes, decoded purely from registered state.
   always_comb begin
      o_busy     = 1'b0;
      o_addr_en  = 1'b0;
      o_addr     = 16'h0000;
      o_rw       = 1'b1;
      o_push_pch = 1'b0;
      o_push_pcl = 1'b0;
      o_push_p   = 1'b0;
      o_b_flag   = 1'b0;
      o_dec_s    = 1'b0;
      o_vec_lo   = 1'b0;
      o_vec_hi   = 1'b0;
      o_set_i    = 1'b0;
      o_done     = 1'b0;
      case (state_q)
         ST_T1: begin
            o_busy = 1'b1;
         end
         ST_T2, ST_T3, ST_T4: begin
            // Reset runs the push cycles as reads so memory is untouched while S still drops by 3.
            o_busy     = 1'b1;
            o_addr_en  = 1'b1;
            o_addr     = {STACK_PAGE, i_s};
            o_rw       = is_rst;
            o_dec_s    = 1'b1;
            o_push_pch = ~is_rst & (state_q == ST_T2);
            o_push_pcl = ~is_rst & (state_q == ST_T3);
            o_push_p   = ~is_rst & (state_q == ST_T4);
            o_b_flag   = (state_q == ST_T4) & (src_q == SRC_BRK);
         end
         ST_T5: begin
            o_busy    = 1'b1;
            o_addr_en = 1'b1;
            o_addr    = vec_q;
            o_vec_lo  = 1'b1;
            o_set_i   = 1'b1;
         end
         ST_T6: begin
            o_busy    = 1'b1;
            o_addr_en = 1'b1;
            o_addr    = vec_q + 16'd1;
            o_vec_hi  = 1'b1;
            o_done    = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         src_q      <= SRC_RST;
         vec_q      <= VEC_RST;
         rst_pend_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         vec_q      <= vec_d;
         rst_pend_q <= rst_pend_d;
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: reset, IRQ, BRK, NMI hijack/deferral, priority and mid-sequence reset.
module tb_int_sequencer;

   logic        i_clk;
   logic        i_rst;
   logic        i_nmi;
   logic        i_irq;
   logic        i_iflag;
   logic        i_fetch;
   logic        i_brk;
   logic [7:0]  i_s;
   logic        o_busy;
   logic        o_force_brk;
   logic        o_addr_en;
   logic [15:0] o_addr;
   logic        o_rw;
   logic        o_push_pch;
   logic        o_push_pcl;
   logic        o_push_p;
   logic        o_b_flag;
   logic        o_dec_s;
   logic        o_vec_lo;
   logic        o_vec_hi;
   logic        o_set_i;
   logic        o_done;

   int passed = 0;
   int total  = 0;

   int_sequencer dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_nmi       (i_nmi),
      .i_irq       (i_irq),
      .i_iflag     (i_iflag),
      .i_fetch     (i_fetch),
      .i_brk       (i_brk),
      .i_s         (i_s),
      .o_busy      (o_busy),
      .o_force_brk (o_force_brk),
      .o_addr_en   (o_addr_en),
      .o_addr      (o_addr),
      .o_rw        (o_rw),
      .o_push_pch  (o_push_pch),
      .o_push_pcl  (o_push_pcl),
      .o_push_p    (o_push_p),
      .o_b_flag    (o_b_flag),
      .o_dec_s     (o_dec_s),
      .o_vec_lo    (o_vec_lo),
      .o_vec_hi    (o_vec_hi),
      .o_set_i     (o_set_i),
      .o_done      (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Packed layout: busy, addr_en, addr[15:0], rw, pch, pcl, p, b, dec_s, vec_lo, vec_hi, set_i, done
   function automatic logic [27:0] ev(input logic busy, input logic aen, input logic [15:0] addr,
                                      input logic rw, input logic pch, input logic pcl, input logic p,
                                      input logic b, input logic dec, input logic vlo, input logic vhi,
                                      input logic seti, input logic done);
      return {busy, aen, addr, rw, pch, pcl, p, b, dec, vlo, vhi, seti, done};
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [27:0] exp);
      logic [27:0] obs;
      #1;
      obs = {o_busy, o_addr_en, o_addr, o_rw, o_push_pch, o_push_pcl, o_push_p,
             o_b_flag, o_dec_s, o_vec_lo, o_vec_hi, o_set_i, o_done};
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_force(input string tag, input logic exp);
      #1;
      total++;
      assert (o_force_brk === exp) passed++;
      else $error("FAIL %s force_brk observed=%b expected=%b", tag, o_force_brk, exp);
   endtask

   // Called in the accept (or BRK) cycle; walks the sequence to the following IDLE cycle.
   // nmi_at raises i_nmi during that state (3 = T3, 5 = T5, 0 = never).
   task automatic run_seq(input string tag, input bit rst_src, input bit brk, input logic [15:0] vec,
                          input bit from_brk, input bit drop_irq, input int nmi_at);
      logic [2:0] push;
      step();
      i_fetch = 1'b0;
      i_brk   = 1'b0;
      if (drop_irq) i_irq = 1'b0;
      if (!from_brk) begin
         chk_out({tag, "_t1"}, ev(1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         step();
      end
      for (int k = 0; k < 3; k++) begin
         if (nmi_at == k + 2) i_nmi = 1'b1;
         push = rst_src ? 3'b000 : (3'b100 >> k);
         chk_out($sformatf("%s_t%0d", tag, k + 2),
                 ev(1, 1, {8'h01, i_s}, rst_src, push[2], push[1], push[0],
                    brk && (k == 2), 1, 0, 0, 0, 0));
         i_s = i_s - 8'd1;
         step();
      end
      if (nmi_at == 5) i_nmi = 1'b1;
      chk_out({tag, "_t5"}, ev(1, 1, vec, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      step();
      chk_out({tag, "_t6"}, ev(1, 1, vec + 16'd1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      step();
      chk_out({tag, "_idle"}, ev(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      i_rst   = 1'b1;
      i_nmi   = 1'b0;
      i_irq   = 1'b0;
      i_iflag = 1'b1;
      i_fetch = 1'b0;
      i_brk   = 1'b0;
      i_s     = 8'hFD;
      step();
      step();
      chk_out("reset_vals", ev(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk_force("reset_force", 1'b0);

      // Power-on reset sequence
      i_rst   = 1'b0;
      i_fetch = 1'b1;
      chk_force("rst_accept", 1'b1);
      run_seq("rst", 1, 0, 16'hFFFC, 0, 0, 0);
      i_fetch = 1'b1;
      chk_force("rst_pend_clear", 1'b0);

      // IRQ masked, then unmasked; IRQ drops after acceptance
      i_irq = 1'b1;
      chk_force("irq_masked", 1'b0);
      i_iflag = 1'b0;
      chk_force("irq_accept", 1'b1);
      run_seq("irq", 0, 0, 16'hFFFE, 0, 1, 0);
      i_iflag = 1'b1;

      // Plain BRK: straight to T2
      i_brk = 1'b1;
      chk_force("brk_no_force", 1'b0);
      run_seq("brk", 0, 1, 16'hFFFE, 1, 0, 0);

      // BRK hijacked by an NMI edge in T3
      i_brk = 1'b1;
      run_seq("brk_nmi3", 0, 1, 16'hFFFA, 1, 0, 3);
      i_nmi   = 1'b0;
      i_fetch = 1'b1;
      chk_force("nmi_pend_cleared", 1'b0);
      i_fetch = 1'b0;
      step();

      // NMI edge in T5 is too late for this BRK and is taken at the next fetch
      i_brk = 1'b1;
      run_seq("brk_nmi5", 0, 1, 16'hFFFE, 1, 0, 5);
      i_nmi   = 1'b0;
      i_fetch = 1'b1;
      chk_force("nmi_deferred", 1'b1);
      run_seq("nmi_late", 0, 0, 16'hFFFA, 0, 0, 0);
      i_fetch = 1'b1;
      chk_force("nmi_late_done", 1'b0);
      i_fetch = 1'b0;
      step();

      // NMI and IRQ together: NMI first, IRQ later only when unmasked
      i_nmi   = 1'b1;
      i_irq   = 1'b1;
      i_iflag = 1'b0;
      step();
      i_fetch = 1'b1;
      chk_force("prio_accept", 1'b1);
      run_seq("prio_nmi", 0, 0, 16'hFFFA, 0, 0, 0);
      i_iflag = 1'b1;
      i_fetch = 1'b1;
      chk_force("prio_irq_masked", 1'b0);
      i_iflag = 1'b0;
      chk_force("prio_irq_accept", 1'b1);
      run_seq("prio_irq", 0, 0, 16'hFFFE, 0, 1, 0);
      i_nmi   = 1'b0;
      i_iflag = 1'b1;

      // Reset asserted in T3 of an IRQ sequence
      i_irq   = 1'b1;
      i_iflag = 1'b0;
      i_fetch = 1'b1;
      chk_force("mid_irq_accept", 1'b1);
      step();
      i_fetch = 1'b0;
      step();
      step();
      chk_out("mid_t3", ev(1, 1, {8'h01, i_s}, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      i_rst = 1'b1;
      chk_out("mid_rst_async", ev(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      i_rst   = 1'b0;
      i_irq   = 1'b0;
      i_iflag = 1'b1;
      i_fetch = 1'b1;
      chk_force("mid_rst_accept", 1'b1);
      run_seq("mid_rst", 1, 0, 16'hFFFC, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
